// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, four-state debounce FSM with a
// stable-sample counter, registered press strobe, level and Up toggle.
module button_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 1_000_000,
  parameter logic UP_INIT         = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Btn_In,
  output logic Up,
  output logic Press_Pulse,
  output logic Btn_Level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       sync_q;
  logic             s;
  logic             up_d, pulse_d, level_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], Btn_In};
  end

  assign s = sync_q[1];

  // State, counter and all outputs are registered together.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      Up          <= UP_INIT;
      Press_Pulse <= 1'b0;
      Btn_Level   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      Up          <= up_d;
      Press_Pulse <= pulse_d;
      Btn_Level   <= level_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      ARM_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Only the ARM_PRESS -> PRESSED transition counts as a press.
  always_comb begin
    up_d    = Up;
    pulse_d = 1'b0;
    level_d = (state_d == PRESSED) || (state_d == ARM_RELEASE);
    if (state == ARM_PRESS && state_d == PRESSED) begin
      pulse_d = 1'b1;
      up_d    = ~Up;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, UP_INIT=1.
module tb_button_debouncer;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Btn_In = 1'b0;
  logic Up, Press_Pulse, Btn_Level;

  int errors = 0;
  int checks = 0;
  int pulses;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .UP_INIT(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Btn_In(Btn_In),
    .Up(Up), .Press_Pulse(Press_Pulse), .Btn_Level(Btn_Level)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge; inputs and samples live on the falling edge.
  task automatic tick();
    @(negedge Clock);
    if (Press_Pulse === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Btn_In = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick(); tick(); tick();
    pulses = 0;
  endtask

  initial begin
    pulses = 0;
    @(negedge Clock);

    // Reset held low with a toggling button: outputs pinned.
    for (int i = 0; i < 6; i++) begin
      Btn_In = i[0];
      tick();
      chk("rst_up", Up, 1'b1);
      chk("rst_pulse", Press_Pulse, 1'b0);
      chk("rst_level", Btn_Level, 1'b0);
    end
    Btn_In = 1'b0;
    Reset = 1'b1;
    tick(); tick(); tick();
    pulses = 0;

    // Clean held press: pulse only after edge 6.
    Btn_In = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("hold_pulse_e%0d", e), Press_Pulse, (e == 6));
      chk($sformatf("hold_up_e%0d", e), Up, (e >= 6) ? 1'b0 : 1'b1);
      chk($sformatf("hold_level_e%0d", e), Btn_Level, (e >= 6));
    end
    chk_int("hold_pulse_count", pulses, 1);

    // Clean release: level drops after edge 6, no pulse, Up kept.
    pulses = 0;
    Btn_In = 1'b0;
    for (int e = 0; e < 9; e++) begin
      tick();
      chk($sformatf("rel_level_e%0d", e), Btn_Level, (e < 6));
      chk($sformatf("rel_up_e%0d", e), Up, 1'b0);
    end
    chk_int("rel_pulse_count", pulses, 0);

    // Short bounces of 1, 2, 3 cycles are rejected.
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      Btn_In = 1'b1;
      for (int i = 0; i < w; i++) tick();
      Btn_In = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("bounce%0d_level", w), Btn_Level, 1'b0);
      end
    end
    chk_int("bounce_pulse_count", pulses, 0);
    chk("bounce_up", Up, 1'b1);

    // Press, 2-cycle release glitch, hold again.
    do_reset();
    Btn_In = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_int("glitch_first_pulse", pulses, 1);
    chk("glitch_up_after_press", Up, 1'b0);
    Btn_In = 1'b0;
    tick(); tick();
    Btn_In = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("glitch_level_%0d", i), Btn_Level, 1'b1);
    end
    chk_int("glitch_pulse_count", pulses, 1);
    chk("glitch_up_final", Up, 1'b0);

    // Three clean press/release cycles: Up 1->0->1->0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulses = 0;
      Btn_In = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk_int($sformatf("cyc%0d_pulses", k), pulses, 1);
      chk($sformatf("cyc%0d_up", k), Up, (k == 1) ? 1'b1 : 1'b0);
      chk($sformatf("cyc%0d_level_on", k), Btn_Level, 1'b1);
      Btn_In = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk($sformatf("cyc%0d_level_off", k), Btn_Level, 1'b0);
    end
    chk_int("cyc_release_pulses", pulses, 1);

    // Reset mid-debounce (ARM_PRESS, cnt=2) with button still held.
    do_reset();
    Btn_In = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_pre_pulse", Press_Pulse, 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_in_pulse", Press_Pulse, 1'b0);
      chk("midrst_in_level", Btn_Level, 1'b0);
      chk("midrst_in_up", Up, 1'b1);
    end
    chk_int("midrst_pulses_so_far", pulses, 0);
    Reset = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk($sformatf("midrst_pulse_e%0d", e), Press_Pulse, (e == 6));
    end
    chk_int("midrst_pulse_count", pulses, 1);
    chk("midrst_up_final", Up, 1'b0);
    chk("midrst_level_final", Btn_Level, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable synchronized samples required (20 ms at 50 MHz); legal range is 2 or more.
REQ-002 Parameter UP_INIT, default 1'b1, is the reset value of Up.
REQ-003 Port Clock, input, 1 bit: single clock; all flops are on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port Btn_In, input, 1 bit: raw push-button level, asynchronous to Clock, 1 = pressed.
REQ-006 Port Up, output, 1 bit: count-direction level that drives the downstream up/down counter's Up input.
REQ-007 Port Press_Pulse, output, 1 bit: single-cycle strobe for each debounced press.
REQ-008 Port Btn_Level, output, 1 bit: debounced button level.

Function
REQ-009 Btn_In SHALL pass through a 2-flop synchronizer; the output of the second flop is the sample s, and no other logic reads Btn_In.
REQ-010 The FSM SHALL have states IDLE, ARM_PRESS, PRESSED and ARM_RELEASE, plus a counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-011 In IDLE, when s=1, the FSM SHALL go to ARM_PRESS and clear cnt to 0; otherwise it stays in IDLE.
REQ-012 In ARM_PRESS:
- if s=0, the FSM SHALL go to IDLE and clear cnt;
- else if cnt==DEBOUNCE_CYCLES-1, it SHALL go to PRESSED;
- else cnt SHALL increment.
REQ-013 On the edge that enters PRESSED from ARM_PRESS, Up SHALL toggle and Press_Pulse SHALL register 1.
- Press_Pulse is high for exactly that one following cycle.
REQ-014 In PRESSED, when s=0, the FSM SHALL go to ARM_RELEASE and clear cnt to 0.
REQ-015 In ARM_RELEASE:
- if s=1, the FSM SHALL return to PRESSED with no pulse and no toggle, and clear cnt;
- else if cnt==DEBOUNCE_CYCLES-1, it SHALL go to IDLE;
- else cnt SHALL increment.
REQ-016 Btn_Level SHALL be 1 exactly when the state is PRESSED or ARM_RELEASE, and SHALL be registered.
REQ-017 Press latency SHALL be DEBOUNCE_CYCLES+2 rising edges, from the first edge that samples Btn_In=1 to the edge that raises Press_Pulse, when the input is stable throughout.
REQ-018 Any press or release bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no Press_Pulse, no Up change and no Btn_Level change.
REQ-019 A release SHALL never generate Press_Pulse or toggle Up.
REQ-020 Press_Pulse SHALL never be high on two consecutive cycles; a held button produces exactly one pulse.
REQ-021 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next edge, with outputs at their reset values except Up, which holds its value.

Reset
REQ-023 While Reset=0, the block SHALL asynchronously force:
- synchronizer flops to 0;
- state to IDLE and cnt to 0;
- Up to UP_INIT;
- Press_Pulse and Btn_Level to 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.
REQ-025 If the button is held through reset deassertion, the press SHALL be debounced as a new press and produce one Press_Pulse after DEBOUNCE_CYCLES+2 edges.
REQ-026 The block SHALL impose no requirement on reset deassertion timing beyond standard recovery/removal timing on Clock.

Verification (DEBOUNCE_CYCLES=4, UP_INIT=1)
REQ-027 Scenario: reset low, Btn_In toggling -> Up=1, Press_Pulse=0, Btn_Level=0 throughout.
REQ-028 Scenario: Btn_In held at 1 from edge 0 -> Press_Pulse=1 only in the cycle after edge 6; Up=0 from edge 6; Btn_Level=1 from edge 6.
REQ-029 Scenario: Btn_In pulses of 1, 2 and 3 cycles separated by 5 cycles of 0 -> no Press_Pulse, Up stays 1, Btn_Level stays 0.
REQ-030 Scenario: a debounced press, then a 2-cycle release glitch, then hold -> exactly one Press_Pulse, Btn_Level remains 1, Up toggles once.
REQ-031 Scenario: three clean press/release cycles (each phase 10 cycles) -> three Press_Pulses, Up sequence 1->0->1->0.
REQ-032 Scenario: Reset asserted while in ARM_PRESS with cnt=2, button still held, then released from reset -> no pulse during reset; one pulse 6 edges after deassertion; Up=0 afterwards.
